// File: rtl/i3c2_job_scheduler_if.sv
// Requester and sequencer-flag bundle for the I2C job scheduler.
// The slave side is the scheduler; the master side drives requests and the sequencer flags.
interface i3c2_job_scheduler_if #(
    parameter int unsigned NREQ = 4
);
    logic [NREQ-1:0] req_i;
    logic [NREQ-1:0] done_o;
    logic [NREQ-1:0] err_o;
    logic            busy_o;
    logic [2:0]      grant_id_o;
    logic [15:0]     seq_inputs_o;
    logic [15:0]     seq_outputs_i;
    logic            seq_error_i;
    logic            timeout_sticky_o;
    logic            fault_o;
    logic            clear_i;

    modport master (
        output req_i, seq_outputs_i, seq_error_i, clear_i,
        input  done_o, err_o, busy_o, grant_id_o, seq_inputs_o,
        input  timeout_sticky_o, fault_o
    );

    modport slave (
        input  req_i, seq_outputs_i, seq_error_i, clear_i,
        output done_o, err_o, busy_o, grant_id_o, seq_inputs_o,
        output timeout_sticky_o, fault_o
    );
endinterface

// File: rtl/i3c2_job_scheduler.sv
// Round-robin scheduler sharing one I2C microcode sequencer between NREQ jobs,
// with a four-phase start/done flag handshake, per-job timeout and fault lockout.
module i3c2_job_scheduler #(
    parameter int unsigned NREQ           = 4,
    parameter int unsigned FLAG_BASE      = 0,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    i3c2_job_scheduler_if.slave  bus
);
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_START    = 2'd1;
    localparam logic [1:0] S_RELEASE  = 2'd2;
    localparam logic [1:0] S_COMPLETE = 2'd3;
    localparam logic [2:0] LAST       = 3'(NREQ - 1);
    localparam logic       TMO_EN     = (TIMEOUT_CYCLES != 24'd0);

    logic [1:0]      state_q, state_d;
    logic [2:0]      rr_q, rr_d;
    logic [2:0]      grant_q, grant_d;
    logic [15:0]     start_q, start_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [NREQ-1:0] err_q, err_d;
    logic [23:0]     tmo_q, tmo_d;
    logic            busy_q, busy_d;
    logic            sticky_q, sticky_d;
    logic            fault_q, fault_d;

    logic [NREQ-1:0] done_flags;
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] gmask;
    logic [2:0]      pick;
    logic [2:0]      rr_next;
    logic            found;
    logic            flag_g;
    logic            tmo_hit;

    assign done_flags = bus.seq_outputs_i[FLAG_BASE +: NREQ];
    // A job whose done pulse is still showing was just served; its request
    // has not yet had a chance to drop.
    assign elig    = bus.req_i & ~done_flags & ~done_q;
    assign gmask   = NREQ'(1) << grant_q;
    assign flag_g  = |(done_flags & gmask);
    assign rr_next = (grant_q == LAST) ? 3'd0 : grant_q + 3'd1;
    assign tmo_hit = TMO_EN && (tmo_q == 24'd1);

    always_comb begin
        int unsigned idx;
        idx   = 0;
        found = 1'b0;
        pick  = rr_q;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (32'(rr_q) + i) % NREQ;
            if (!found && ((elig >> idx) & NREQ'(1)) != '0) begin
                found = 1'b1;
                pick  = 3'(idx);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        grant_d  = grant_q;
        start_d  = start_q;
        done_d   = '0;
        err_d    = '0;
        tmo_d    = tmo_q;
        sticky_d = sticky_q;
        fault_d  = fault_q;

        if (bus.clear_i) begin
            sticky_d = 1'b0;
            fault_d  = 1'b0;
        end
        if (bus.seq_error_i) fault_d = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (found && !fault_q) begin
                    grant_d = pick;
                    start_d = 16'd1 << (FLAG_BASE + 32'(pick));
                    tmo_d   = TIMEOUT_CYCLES;
                    state_d = S_START;
                end
            end
            S_START, S_RELEASE: begin
                if (TMO_EN) tmo_d = tmo_q - 24'd1;
                // Timeout wins over a same-cycle handshake step and over clear_i.
                if (tmo_hit) begin
                    start_d  = '0;
                    done_d   = gmask;
                    err_d    = gmask;
                    sticky_d = 1'b1;
                    rr_d     = rr_next;
                    state_d  = S_IDLE;
                end else if (state_q == S_START && flag_g) begin
                    start_d = '0;
                    state_d = S_RELEASE;
                end else if (state_q == S_RELEASE && !flag_g) begin
                    done_d  = gmask;
                    state_d = S_COMPLETE;
                end
            end
            S_COMPLETE: begin
                rr_d    = rr_next;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rr_q     <= '0;
            grant_q  <= '0;
            start_q  <= '0;
            done_q   <= '0;
            err_q    <= '0;
            tmo_q    <= '0;
            busy_q   <= 1'b0;
            sticky_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            grant_q  <= grant_d;
            start_q  <= start_d;
            done_q   <= done_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
            busy_q   <= busy_d;
            sticky_q <= sticky_d;
            fault_q  <= fault_d;
        end
    end

    assign bus.seq_inputs_o     = start_q;
    assign bus.done_o           = done_q;
    assign bus.err_o            = err_q;
    assign bus.busy_o           = busy_q;
    assign bus.grant_id_o       = grant_q;
    assign bus.timeout_sticky_o = sticky_q;
    assign bus.fault_o          = fault_q;
endmodule

// File: tb/tb_i3c2_job_scheduler.sv
// Bench for i3c2_job_scheduler: directed scenarios plus random requests
// against a sequencer model and a round-robin reference model.
module tb_i3c2_job_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i3c2_job_scheduler_if #(.NREQ(4)) ifc ();

    i3c2_job_scheduler #(
        .NREQ(4),
        .FLAG_BASE(0),
        .TIMEOUT_CYCLES(24'd100)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(ifc)
    );

    int total = 0;
    int bad = 0;

    logic [3:0]  req_man = '0;
    logic [3:0]  req_auto = '0;
    logic [15:0] model_out = '0;
    logic [15:0] man_out = '0;
    logic        seq_err = 1'b0;
    logic        clr = 1'b0;
    logic        never = 1'b0;
    logic        auto_en = 1'b0;
    int          up_dly = 50;
    int          dn_dly = 10;
    int          hi_cnt [16];
    int          lo_cnt [16];

    assign ifc.req_i         = req_man | req_auto;
    assign ifc.seq_outputs_i = model_out | man_out;
    assign ifc.seq_error_i   = seq_err;
    assign ifc.clear_i       = clr;

    // Sequencer: raise done up_dly cycles after start, drop it dn_dly cycles after start falls.
    always @(posedge clk) begin
        for (int k = 0; k < 16; k++) begin
            if (ifc.seq_inputs_o[k]) begin
                lo_cnt[k] <= 0;
                hi_cnt[k] <= hi_cnt[k] + 1;
                if (!never && hi_cnt[k] + 1 >= up_dly) model_out[k] <= 1'b1;
            end else begin
                hi_cnt[k] <= 0;
                if (model_out[k]) begin
                    lo_cnt[k] <= lo_cnt[k] + 1;
                    if (lo_cnt[k] + 1 >= dn_dly) model_out[k] <= 1'b0;
                end else begin
                    lo_cnt[k] <= 0;
                end
            end
        end
    end

    // Random requesters: hold the request until the done pulse is seen.
    always @(negedge clk) begin
        if (!auto_en) req_auto = '0;
        else
            for (int k = 0; k < 4; k++) begin
                if (ifc.done_o[k]) req_auto[k] = 1'b0;
                else if (!req_auto[k] && $urandom_range(0, 5) == 0) req_auto[k] = 1'b1;
            end
    end

    // Reference: next grant is the first pending job (request up, done flag low)
    // in circular order after the last finished job; none while faulted.
    logic [3:0]  s_req;
    logic [15:0] s_out;
    logic [15:0] s_in;
    logic        s_fault;
    int          rr_m = 0;
    int          grants_n = 0;
    int          dones_n = 0;

    always @(posedge clk) begin
        s_req   = ifc.req_i;
        s_out   = ifc.seq_outputs_i;
        s_in    = ifc.seq_inputs_o;
        s_fault = ifc.fault_o;
    end

    always @(negedge clk) begin : mon
        int exp_k;
        if (!rst_n) begin
            rr_m = 0;
        end else begin
            total++;
            assert ($onehot0(ifc.seq_inputs_o) && ifc.seq_inputs_o[15:4] == 12'h0)
            else begin
                bad++;
                $error("FAIL onehot obs=%h exp=onehot0", ifc.seq_inputs_o);
            end
            if (s_in == 16'h0 && ifc.seq_inputs_o != 16'h0) begin
                grants_n++;
                exp_k = -1;
                if (!s_fault)
                    for (int i = 0; i < 4; i++) begin
                        int k;
                        k = (rr_m + i) % 4;
                        if (exp_k < 0 && s_req[k] && !s_out[k]) exp_k = k;
                    end
                total++;
                assert (exp_k >= 0 && int'(ifc.grant_id_o) == exp_k
                        && ifc.seq_inputs_o == (16'd1 << exp_k))
                else begin
                    bad++;
                    $error("FAIL grant obs=%0d/%h exp=%0d", ifc.grant_id_o,
                           ifc.seq_inputs_o, exp_k);
                end
            end
            if (ifc.done_o != 4'h0) dones_n++;
            for (int k = 0; k < 4; k++)
                if (ifc.done_o[k]) rr_m = (k + 1) % 4;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag, input logic [3:0] exp, input int lim);
        int n;
        n = 0;
        while (ifc.done_o == 4'h0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(ifc.done_o), 32'(exp));
    endtask

    initial begin
        int n;
        int diff0;
        cyc(3);
        chk("rst_in", 32'(ifc.seq_inputs_o), 0);
        chk("rst_done", 32'(ifc.done_o), 0);
        chk("rst_err", 32'(ifc.err_o), 0);
        chk("rst_busy", 32'(ifc.busy_o), 0);
        chk("rst_gid", 32'(ifc.grant_id_o), 0);
        chk("rst_stky", 32'(ifc.timeout_sticky_o), 0);
        chk("rst_flt", 32'(ifc.fault_o), 0);
        rst_n = 1'b1;
        cyc(2);

        // single job
        req_man = 4'b0001;
        cyc(1);
        chk("t1_start", 32'(ifc.seq_inputs_o), 1);
        chk("t1_busy", 32'(ifc.busy_o), 1);
        wait_done("t1_done", 4'b0001, 200);
        chk("t1_err", 32'(ifc.err_o), 0);
        req_man = 4'b0000;
        cyc(1);
        chk("t1_once", 32'(ifc.done_o), 0);
        cyc(1);
        chk("t1_idle", 32'(ifc.busy_o), 0);

        // round robin from a fresh pointer
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        up_dly = 10;
        dn_dly = 5;
        req_man = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            wait_done($sformatf("rr%0d", j), 4'(1 << (j % 4)), 100);
            if (j == 4) req_man = 4'b0000;
            cyc(1);
        end
        cyc(2);
        chk("rr_idle", 32'(ifc.busy_o), 0);

        // timeout
        never = 1'b1;
        req_man = 4'b0001;
        cyc(1);
        chk("t3_start", 32'(ifc.seq_inputs_o), 1);
        n = 0;
        while (ifc.seq_inputs_o[0] && n < 300) begin
            n++;
            cyc(1);
        end
        chk("t3_len", 32'(n), 100);
        chk("t3_done", 32'(ifc.done_o), 1);
        chk("t3_err", 32'(ifc.err_o), 1);
        chk("t3_stky", 32'(ifc.timeout_sticky_o), 1);
        req_man = 4'b0000;
        never = 1'b0;
        cyc(1);
        chk("t3_once", 32'(ifc.done_o), 0);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        chk("t3_clr", 32'(ifc.timeout_sticky_o), 0);

        // stale done flag blocks re-grant of job 0
        man_out = 16'h0001;
        req_man = 4'b0001;
        cyc(10);
        chk("t4_block", 32'(ifc.busy_o), 0);
        req_man = 4'b0011;
        cyc(1);
        chk("t4_j1", 32'(ifc.seq_inputs_o), 32'h2);
        wait_done("t4_j1done", 4'b0010, 100);
        req_man = 4'b0001;
        cyc(5);
        chk("t4_still", 32'(ifc.busy_o), 0);
        man_out = 16'h0000;
        cyc(1);
        chk("t4_j0", 32'(ifc.seq_inputs_o), 1);
        wait_done("t4_j0done", 4'b0001, 100);
        req_man = 4'b0000;
        cyc(2);

        // fault lockout
        req_man = 4'b0100;
        cyc(1);
        chk("t5_j2", 32'(ifc.seq_inputs_o), 32'h4);
        cyc(3);
        seq_err = 1'b1;
        cyc(1);
        seq_err = 1'b0;
        req_man = 4'b1100;
        cyc(1);
        chk("t5_flt", 32'(ifc.fault_o), 1);
        wait_done("t5_j2done", 4'b0100, 100);
        req_man = 4'b1000;
        cyc(10);
        chk("t5_lock", 32'(ifc.busy_o), 0);
        chk("t5_flt2", 32'(ifc.fault_o), 1);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        chk("t5_clr", 32'(ifc.fault_o), 0);
        cyc(1);
        chk("t5_j3", 32'(ifc.seq_inputs_o), 32'h8);
        chk("t5_gid", 32'(ifc.grant_id_o), 3);
        wait_done("t5_j3done", 4'b1000, 100);
        req_man = 4'b0000;
        cyc(2);

        // reset mid-job, pointer restarts at 0
        req_man = 4'b0100;
        cyc(1);
        wait_done("t6_pre", 4'b0100, 100);
        req_man = 4'b0000;
        cyc(2);
        req_man = 4'b1001;
        cyc(1);
        chk("t6_j3", 32'(ifc.seq_inputs_o), 32'h8);
        cyc(3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async", 32'(ifc.seq_inputs_o), 0);
        chk("t6_busy", 32'(ifc.busy_o), 0);
        cyc(3);
        chk("t6_nodone", 32'(ifc.done_o), 0);
        rst_n = 1'b1;
        cyc(1);
        chk("t6_regrant", 32'(ifc.seq_inputs_o), 1);
        wait_done("t6_done", 4'b0001, 100);
        req_man = 4'b0000;
        cyc(2);

        // random requests, reference model checks every grant
        diff0 = grants_n - dones_n;
        auto_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            cyc(1);
            if (ifc.done_o != 4'h0) begin
                up_dly = $urandom_range(1, 30);
                dn_dly = $urandom_range(1, 10);
            end
        end
        auto_en = 1'b0;
        n = 0;
        while (ifc.busy_o && n < 200) begin
            n++;
            cyc(1);
        end
        cyc(2);
        chk("rnd_idle", 32'(ifc.busy_o), 0);
        chk("rnd_jobs", 32'(grants_n - dones_n), 32'(diff0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
